// File: rtl/carfield_xilinx_rst_seq.sv
// Reset sequencer for the Xilinx Carfield target: waits for DRAM calibration, releases the
// memory-side reset, then the SoC power-on reset. Optional timeout flag: CARFIELD_RSTSEQ_CALIB_TIMEOUT_EN.
module carfield_xilinx_rst_seq #(
  parameter int unsigned HoldCycles   = 64,
  parameter int unsigned StageGap     = 16,
  parameter int unsigned CalibTimeout = 2**20,
  parameter int unsigned SyncStages   = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       calib_done_i,
  input  logic       sw_rst_req_i,
  output logic       mem_rst_no,
  output logic       soc_rst_no,
  output logic       calib_timeout_o,
  output logic [1:0] rst_cause_o,
  output logic [2:0] state_o
);

  localparam int unsigned MaxCnt = (HoldCycles > StageGap) ? HoldCycles : StageGap;
  localparam int unsigned CntW   = ($clog2(MaxCnt) > 0) ? $clog2(MaxCnt) : 1;

  typedef enum logic [2:0] {
    RESET      = 3'd0,
    WAIT_CALIB = 3'd1,
    HOLD       = 3'd2,
    MEM_UP     = 3'd3,
    RUN        = 3'd4
  } state_e;

  localparam logic [1:0] CauseNone = 2'b00;
  localparam logic [1:0] CauseSw   = 2'b01;
  localparam logic [1:0] CauseCal  = 2'b10;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [1:0]        cause_q, cause_d;
  logic              mem_q, soc_q;
  logic [SyncStages-1:0] sync_q;
  logic              cal_s;

  // calib_done_i comes from the MIG domain; only the last flop of the chain is used.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= '0;
    else       sync_q <= {sync_q[SyncStages-2:0], calib_done_i};
  end

  assign cal_s = sync_q[SyncStages-1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RESET;
      cnt_q   <= '0;
      cause_q <= CauseNone;
      mem_q   <= 1'b0;
      soc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      mem_q   <= (state_d == MEM_UP) || (state_d == RUN);
      soc_q   <= (state_d == RUN);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    unique case (state_q)
      RESET: begin
        state_d = WAIT_CALIB;
        cnt_d   = '0;
      end
      WAIT_CALIB: begin
        if (cal_s) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        if (cnt_q == CntW'(HoldCycles - 1)) begin
          state_d = MEM_UP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      MEM_UP: begin
        if (cnt_q == CntW'(StageGap - 1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d = RESET;
        cnt_d   = '0;
      end
    endcase

    // Re-entry events override normal sequencing; calibration loss takes priority.
    if ((state_q == HOLD) || (state_q == MEM_UP) || (state_q == RUN)) begin
      if (!cal_s) begin
        state_d = WAIT_CALIB;
        cnt_d   = '0;
        cause_d = CauseCal;
      end else if (sw_rst_req_i) begin
        state_d = HOLD;
        cnt_d   = '0;
        cause_d = CauseSw;
      end
    end
  end

`ifdef CARFIELD_RSTSEQ_CALIB_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(CalibTimeout);

  logic [ToW-1:0] to_cnt_q;
  logic           to_flag_q;

  // Counter parks at its terminal value; the flag is sticky until rst_i.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      to_cnt_q  <= '0;
      to_flag_q <= 1'b0;
    end else begin
      if (state_q != WAIT_CALIB) begin
        to_cnt_q <= '0;
      end else if (!cal_s && (to_cnt_q != ToW'(CalibTimeout - 1))) begin
        to_cnt_q <= to_cnt_q + 1'b1;
      end
      if ((state_q == WAIT_CALIB) && (to_cnt_q == ToW'(CalibTimeout - 1))) begin
        to_flag_q <= 1'b1;
      end
    end
  end

  assign calib_timeout_o = to_flag_q;
`else
  // No timeout logic in this build; the comparison folds to a constant 0.
  assign calib_timeout_o = (CalibTimeout < 0);
`endif

  assign mem_rst_no  = mem_q;
  assign soc_rst_no  = soc_q;
  assign rst_cause_o = cause_q;
  assign state_o     = state_q;

endmodule
